pingpong_reorder_buf: RTL and testbench

PINGPONG_REORDER_BUF -- requirements
Module: pingpong_reorder_buf

---
 rtl/pingpong_reorder_buf.sv | 127 ++++++++++++
 tb/tb_pingpong_reorder_buf.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pingpong_reorder_buf.sv
// Two-bank ping-pong frame buffer: one bank fills while the other is read out.
// Define PINGPONG_BITREV_EN to read each frame in bit-reversed address order.
module pingpong_reorder_buf #(
    parameter int NB   = 12,
    parameter int LOGN = 8
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          ED,
    input  logic          START,
    input  logic          IVLD,
    input  logic [NB-1:0] DR,
    input  logic [NB-1:0] DI,
    output logic          OVLD,
    output logic          FSTART,
    output logic [NB-1:0] DOR,
    output logic [NB-1:0] DOI,
    output logic          RBANK
);

    localparam int N = 1 << LOGN;
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_READ = 1'b1;

    logic [2*NB-1:0] r_mem [0:2*N-1];

    logic [LOGN-1:0] r_wcnt;
    logic [LOGN-1:0] r_rcnt;
    logic [0:0]      r_state;
    logic            r_rbank;

    logic            r_vld_p0;
    logic            r_fst_p0;
    logic [LOGN:0]   r_raddr_p0;
    logic            r_vld_p1;
    logic            r_fst_p1;
    logic [2*NB-1:0] r_rdata_p1;
    logic            r_ovld_p2;
    logic            r_fst_p2;
    logic [NB-1:0]   r_dor_p2;
    logic [NB-1:0]   r_doi_p2;

    logic [LOGN-1:0] w_waddr;
    logic [LOGN-1:0] w_rdaddr;
    logic            w_swap;
    logic            w_rwrap;

`ifdef PINGPONG_BITREV_EN
    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
        return r;
    endfunction
    assign w_rdaddr = bitrev(r_rcnt);
`else
    assign w_rdaddr = r_rcnt;
`endif

    // START realigns the frame, so a coincident sample always lands at address 0
    assign w_waddr = START ? '0 : r_wcnt;
    assign w_swap  = IVLD && !START && (&r_wcnt);
    assign w_rwrap = &r_rcnt;

    always_ff @(posedge CLK) begin
        if (ED) begin
            if (IVLD) r_mem[{~r_rbank, w_waddr}] <= {DR, DI};
            r_raddr_p0 <= {r_rbank, w_rdaddr};
            r_rdata_p1 <= r_mem[r_raddr_p0];
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_wcnt    <= '0;
            r_rcnt    <= '0;
            r_state   <= S_IDLE;
            r_rbank   <= 1'b0;
            r_vld_p0  <= 1'b0;
            r_fst_p0  <= 1'b0;
            r_vld_p1  <= 1'b0;
            r_fst_p1  <= 1'b0;
            r_ovld_p2 <= 1'b0;
            r_fst_p2  <= 1'b0;
            r_dor_p2  <= '0;
            r_doi_p2  <= '0;
        end else if (ED) begin
            if (START)     r_wcnt <= IVLD ? LOGN'(1) : '0;
            else if (IVLD) r_wcnt <= r_wcnt + LOGN'(1);

            if (w_swap) r_rbank <= ~r_rbank;

            case (r_state)
                S_IDLE: begin
                    if (w_swap) begin
                        r_state <= S_READ;
                        r_rcnt  <= '0;
                    end
                end
                default: begin
                    r_rcnt <= w_swap ? '0 : r_rcnt + LOGN'(1);
                    if (w_rwrap && !w_swap) r_state <= S_IDLE;
                end
            endcase

            // stage p0: read address issued
            r_vld_p0 <= (r_state == S_READ);
            r_fst_p0 <= (r_state == S_READ) && (r_rcnt == '0);
            // stage p1: RAM word registered
            r_vld_p1 <= r_vld_p0;
            r_fst_p1 <= r_fst_p0;
            // stage p2: output register, holds last sample while idle
            r_ovld_p2 <= r_vld_p1;
            r_fst_p2  <= r_fst_p1;
            if (r_vld_p1) begin
                r_dor_p2 <= r_rdata_p1[2*NB-1:NB];
                r_doi_p2 <= r_rdata_p1[NB-1:0];
            end
        end
    end

    assign OVLD   = r_ovld_p2;
    assign FSTART = r_fst_p2;
    assign DOR    = r_dor_p2;
    assign DOI    = r_doi_p2;
    assign RBANK  = r_rbank;

endmodule

// File: tb/tb_pingpong_reorder_buf.sv
// Directed bench for pingpong_reorder_buf (LOGN=8, NB=12); expected order follows
// PINGPONG_BITREV_EN when the bench is built with it.
module tb_pingpong_reorder_buf;

    localparam int NB   = 12;
    localparam int LOGN = 8;
    localparam int N    = 256;

    logic          CLK   = 1'b0;
    logic          RSTN  = 1'b0;
    logic          ED    = 1'b0;
    logic          START = 1'b0;
    logic          IVLD  = 1'b0;
    logic [NB-1:0] DR    = '0;
    logic [NB-1:0] DI    = '0;
    logic          OVLD;
    logic          FSTART;
    logic [NB-1:0] DOR;
    logic [NB-1:0] DOI;
    logic          RBANK;

    int n_vec = 0;
    int n_err = 0;

    pingpong_reorder_buf #(.NB(NB), .LOGN(LOGN)) dut (
        .CLK(CLK), .RSTN(RSTN), .ED(ED), .START(START), .IVLD(IVLD),
        .DR(DR), .DI(DI), .OVLD(OVLD), .FSTART(FSTART),
        .DOR(DOR), .DOI(DOI), .RBANK(RBANK)
    );

    always #5 CLK = ~CLK;

    function automatic int brv(input int a);
`ifdef PINGPONG_BITREV_EN
        int r;
        r = 0;
        for (int i = 0; i < LOGN; i++) if (a[i]) r = r | (1 << (LOGN - 1 - i));
        return r;
`else
        return a;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit ed, input bit st, input bit iv, input int dr, input int di);
        ED    = ed;
        START = st;
        IVLD  = iv;
        DR    = dr[NB-1:0];
        DI    = di[NB-1:0];
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        ED = 1'b0; START = 1'b0; IVLD = 1'b0;
        RSTN = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RSTN = 1'b1;
        chk("rst_ovld", OVLD, 0);
        chk("rst_fstart", FSTART, 0);
        chk("rst_dor", DOR, 0);
        chk("rst_doi", DOI, 0);
        chk("rst_rbank", RBANK, 0);
    endtask

    // Streams nf frames (sample k of each frame: DR=k, DI=255-k) and checks every cycle.
    // With tog set, every other cycle has ED=0 with junk inputs that must be ignored.
    task automatic stream(input int nf, input bit tog);
        int q, c, lo, hi, last_q, idx, d, sw;
        bit ed;
        logic p_ov, p_fs, p_rb;
        logic [NB-1:0] p_dor, p_doi;
        q = 0; c = 0;
        lo = 2 * N / N + N + 1;
        lo = N + 3;
        hi = N + 2 + N * nf;
        last_q = hi + 2;
        p_ov = OVLD; p_fs = FSTART; p_rb = RBANK; p_dor = DOR; p_doi = DOI;
        while (q < last_q) begin
            ed = tog ? c[0] : 1'b1;
            c++;
            if (ed) begin
                if (q + 1 <= N * nf) begin
                    d = q % N;
                    drive(1, 0, 1, d, 255 - d);
                end else begin
                    drive(1, 0, 0, 0, 0);
                end
                q++;
                sw = (q / N < nf) ? q / N : nf;
                chk("rbank", RBANK, sw % 2);
                if (q >= lo && q <= hi) begin
                    idx = (q - lo) % N;
                    chk("ovld_hi", OVLD, 1);
                    chk("fstart", FSTART, (idx == 0) ? 1 : 0);
                    chk("dor", DOR, brv(idx));
                    chk("doi", DOI, 255 - brv(idx));
                end else begin
                    chk("ovld_lo", OVLD, 0);
                    chk("fstart_lo", FSTART, 0);
                    if (q > hi) begin
                        chk("dor_hold", DOR, brv(N - 1));
                        chk("doi_hold", DOI, 255 - brv(N - 1));
                    end
                end
            end else begin
                drive(0, 1, 1, 12'hABC, 12'h123);
                chk("frz_ovld", OVLD, p_ov);
                chk("frz_fstart", FSTART, p_fs);
                chk("frz_dor", DOR, p_dor);
                chk("frz_doi", DOI, p_doi);
                chk("frz_rbank", RBANK, p_rb);
            end
            p_ov = OVLD; p_fs = FSTART; p_rb = RBANK; p_dor = DOR; p_doi = DOI;
        end
    endtask

    initial begin
        // single frame, latency and order
        do_reset();
        stream(1, 0);

        // three back-to-back frames, gapless output
        do_reset();
        stream(3, 0);

        // clock enable toggling every cycle
        do_reset();
        stream(1, 1);

        // START realignment discards the partial frame
        do_reset();
        for (int k = 0; k < 100; k++) begin
            drive(1, 0, 1, 1000 + k, 2000 + k);
            chk("st_pre_ovld", OVLD, 0);
        end
        drive(1, 1, 1, 7, 3);
        chk("st_edge_ovld", OVLD, 0);
        for (int k = 0; k < N - 1; k++) begin
            drive(1, 0, 1, k + 8, 3);
            chk("st_fill_ovld", OVLD, 0);
        end
        drive(1, 0, 0, 0, 0);
        chk("st_lat1_ovld", OVLD, 0);
        drive(1, 0, 0, 0, 0);
        chk("st_lat2_ovld", OVLD, 0);
        for (int j = 0; j < N; j++) begin
            drive(1, 0, 0, 0, 0);
            chk("st_ovld", OVLD, 1);
            chk("st_fstart", FSTART, (j == 0) ? 1 : 0);
            chk("st_dor", DOR, brv(j) + 7);
            chk("st_doi", DOI, 3);
        end
        drive(1, 0, 0, 0, 0);
        chk("st_end_ovld", OVLD, 0);

        // asynchronous reset while a frame is being output
        do_reset();
        for (int k = 0; k < N; k++) drive(1, 0, 1, k, 255 - k);
        repeat (23) drive(1, 0, 0, 0, 0);
        chk("mr_ovld_before", OVLD, 1);
        chk("mr_dor_before", DOR, brv(20));
        #3 RSTN = 1'b0;
        #1;
        chk("mr_ovld", OVLD, 0);
        chk("mr_fstart", FSTART, 0);
        chk("mr_dor", DOR, 0);
        chk("mr_doi", DOI, 0);
        chk("mr_rbank", RBANK, 0);
        @(posedge CLK);
        #1 RSTN = 1'b1;
        chk("mr_ovld_rel", OVLD, 0);
        stream(1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
